truth_table_sweeper: RTL and testbench

Sequencer that characterises one N-input combinational gate (e.g. the 3-input truth-table gate modules) by driving every input combination in order. It waits a programmable settle time per row, samples the gate output and assembles the measured truth table. It then compares the result against an expected table. It sits between a test/config controller (start/expected) and one gate instance (dut_in/dut_out).

---
 rtl/truth_table_sweeper.sv | 157 +++++++++++++++
 tb/tb_truth_table_sweeper.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - sweeps every input row of an N-input gate and assembles its truth table.
// Optional abort with restore of the previous results: define SWEEP_ABORT_EN.
module truth_table_sweeper #(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 4,
  localparam int T            = 2 ** N_IN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [T-1:0]    expected,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic [T-1:0]    table_out,
  output logic            match,
  output logic [T-1:0]    mismatch_mask
`ifdef SWEEP_ABORT_EN
  ,
  input  logic            abort
`endif
);

  typedef enum logic [1:0] {IDLE, SWEEP, FINISH} state_t;

  state_t            state_q, state_d;
  logic [N_IN:0]     row_q, row_d;
  logic [7:0]        settle_q, settle_d;
  logic [N_IN-1:0]   dut_in_q, dut_in_d;
  logic [T-1:0]      exp_q, exp_d;
  logic [T-1:0]      table_q, table_d;
  logic              match_q, match_d;
  logic [T-1:0]      mask_q, mask_d;
  logic [N_IN-1:0]   bit_idx;

`ifdef SWEEP_ABORT_EN
  logic [T-1:0]      table_sh_q, table_sh_d;
  logic              match_sh_q, match_sh_d;
  logic [T-1:0]      mask_sh_q, mask_sh_d;
`endif

  // Cello ordering: row k lands in bit T-1-k, which is simply ~k for k < T.
  assign bit_idx = ~row_q[N_IN-1:0];

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    settle_d = settle_q;
    dut_in_d = dut_in_q;
    exp_d    = exp_q;
    table_d  = table_q;
    match_d  = match_q;
    mask_d   = mask_q;
`ifdef SWEEP_ABORT_EN
    table_sh_d = table_sh_q;
    match_sh_d = match_sh_q;
    mask_sh_d  = mask_sh_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef SWEEP_ABORT_EN
          table_sh_d = table_q;
          match_sh_d = match_q;
          mask_sh_d  = mask_q;
`endif
          exp_d    = expected;
          table_d  = '0;
          match_d  = 1'b0;
          mask_d   = '0;
          row_d    = '0;
          dut_in_d = '0;
          settle_d = 8'(SETTLE_CYCLES);
          state_d  = SWEEP;
        end
      end
      SWEEP: begin
        if (settle_q == 8'd0) begin
          table_d[bit_idx] = dut_out;
          if (row_q == (N_IN+1)'(T-1)) begin
            dut_in_d = '0;
            match_d  = (table_d == exp_q);
            mask_d   = table_d ^ exp_q;
            state_d  = FINISH;
          end else begin
            row_d    = row_q + 1'b1;
            dut_in_d = row_d[N_IN-1:0];
            settle_d = 8'(SETTLE_CYCLES);
          end
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef SWEEP_ABORT_EN
    // Abort wins over everything in SWEEP and rolls results back to the pre-sweep copy.
    if (abort && state_q == SWEEP) begin
      state_d  = IDLE;
      dut_in_d = '0;
      row_d    = '0;
      settle_d = 8'd0;
      table_d  = table_sh_q;
      match_d  = match_sh_q;
      mask_d   = mask_sh_q;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      row_q    <= '0;
      settle_q <= 8'd0;
      dut_in_q <= '0;
      exp_q    <= '0;
      table_q  <= '0;
      match_q  <= 1'b0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      settle_q <= settle_d;
      dut_in_q <= dut_in_d;
      exp_q    <= exp_d;
      table_q  <= table_d;
      match_q  <= match_d;
      mask_q   <= mask_d;
    end
  end

`ifdef SWEEP_ABORT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      table_sh_q <= '0;
      match_sh_q <= 1'b0;
      mask_sh_q  <= '0;
    end else begin
      table_sh_q <= table_sh_d;
      match_sh_q <= match_sh_d;
      mask_sh_q  <= mask_sh_d;
    end
  end
`endif

  assign dut_in        = dut_in_q;
  assign busy          = (state_q == SWEEP);
  assign done          = (state_q == FINISH);
  assign table_out     = table_q;
  assign match         = match_q;
  assign mismatch_mask = mask_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - table-driven bench for truth_table_sweeper (N_IN=3, S=4 and S=0 instances).
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start, start0;
  logic [7:0] expected, expected0;
  logic [7:0] gate_tt;
  logic [2:0] dut_in, dut_in0;
  logic       dut_out, dut_out0;
  logic       busy, busy0, done, done0, match, match0;
  logic [7:0] table_out, table0, mismatch_mask, mask0;
`ifdef SWEEP_ABORT_EN
  logic       abort, abort0;
`endif

  int tests = 0;
  int fails = 0;

  // Gate model: row k drives truth-table bit 7-k.
  assign dut_out  = gate_tt[~dut_in];
  assign dut_out0 = 1'b1;

  truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .expected(expected),
    .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done),
    .table_out(table_out), .match(match), .mismatch_mask(mismatch_mask)
`ifdef SWEEP_ABORT_EN
    , .abort(abort)
`endif
  );

  truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .expected(expected0),
    .dut_in(dut_in0), .dut_out(dut_out0), .busy(busy0), .done(done0),
    .table_out(table0), .match(match0), .mismatch_mask(mask0)
`ifdef SWEEP_ABORT_EN
    , .abort(abort0)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  // One sweep on the S=4 instance; start sampled at the end of cycle 0.
  task automatic do_sweep(input logic [7:0] exp_v, input bit disturb, input int abort_at,
                          output int dones, output int done_cyc, output int seq_err, output int clr_err);
    logic [2:0] want_in;
    logic       want_busy;
    dones = 0; done_cyc = -1; seq_err = 0; clr_err = 0;
    @(negedge clk);
    expected = exp_v;
    start    = 1'b1;
    for (int c = 1; c <= 44; c++) begin
      @(negedge clk);
      start = disturb && (c == 10);
      if (disturb && c == 12) expected = 8'h00;
`ifdef SWEEP_ABORT_EN
      abort = (c == abort_at);
`endif
      if (done) begin dones++; done_cyc = c; end
      want_busy = (c <= 40) && (abort_at < 0 || c <= abort_at);
      want_in   = want_busy ? 3'((c - 1) / 5) : 3'd0;
      if (dut_in !== want_in || busy !== want_busy) seq_err++;
      if (c == 1 && (table_out !== 8'h00 || match !== 1'b0 || mismatch_mask !== 8'h00)) clr_err++;
    end
  endtask

  typedef struct {
    logic [7:0] gate;
    logic [7:0] exp_v;
    bit         disturb;
    logic [7:0] want_tbl;
    logic       want_match;
    logic [7:0] want_mask;
  } vec_t;

  vec_t vecs[6];
  int   dones, done_cyc, seq_err, clr_err;
  int   d0_cnt, d0_cyc, s0_err, d_first, d_second;

  initial begin
    vecs[0] = '{8'h92, 8'h92, 1'b0, 8'h92, 1'b1, 8'h00};
    vecs[1] = '{8'h92, 8'h93, 1'b0, 8'h92, 1'b0, 8'h01};
    vecs[2] = '{8'h92, 8'h92, 1'b1, 8'h92, 1'b1, 8'h00};
    vecs[3] = '{8'hA5, 8'h00, 1'b0, 8'hA5, 1'b0, 8'hA5};
    vecs[4] = '{8'h01, 8'h01, 1'b0, 8'h01, 1'b1, 8'h00};
    vecs[5] = '{8'h80, 8'h81, 1'b0, 8'h80, 1'b0, 8'h01};

    rst = 1'b1; start = 1'b0; start0 = 1'b0;
    expected = 8'h00; expected0 = 8'hFF; gate_tt = 8'h00;
`ifdef SWEEP_ABORT_EN
    abort = 1'b0; abort0 = 1'b0;
`endif
    #1;
    chk("reset_outputs", {dut_in, busy, done, match, table_out, mismatch_mask}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      gate_tt = vecs[i].gate;
      do_sweep(vecs[i].exp_v, vecs[i].disturb, -1, dones, done_cyc, seq_err, clr_err);
      chk($sformatf("v%0d_done_count", i), dones, 1);
      chk($sformatf("v%0d_done_cycle", i), done_cyc, 41);
      chk($sformatf("v%0d_dut_in_busy_seq", i), seq_err, 0);
      chk($sformatf("v%0d_clear_on_start", i), clr_err, 0);
      chk($sformatf("v%0d_table", i), table_out, vecs[i].want_tbl);
      chk($sformatf("v%0d_match", i), match, vecs[i].want_match);
      chk($sformatf("v%0d_mask", i), mismatch_mask, vecs[i].want_mask);
    end

    // S=0, gate tied high: one row per cycle, done in cycle 9.
    d0_cnt = 0; d0_cyc = -1; s0_err = 0;
    @(negedge clk);
    start0 = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (done0) begin d0_cnt++; d0_cyc = c; end
      if (c <= 8 && dut_in0 !== 3'(c - 1)) s0_err++;
    end
    chk("s0_done_count", d0_cnt, 1);
    chk("s0_done_cycle", d0_cyc, 9);
    chk("s0_dut_in_seq", s0_err, 0);
    chk("s0_table", table0, 8'hFF);
    chk("s0_match", match0, 1'b1);

    // Start held high: second sweep's row 0 follows one IDLE cycle after done.
    gate_tt = 8'h92; expected = 8'h92;
    d_first = -1; d_second = -1; dones = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 90; c++) begin
      @(negedge clk);
      if (c == 60) start = 1'b0;
      if (done) begin
        dones++;
        if (d_first < 0) d_first = c; else if (d_second < 0) d_second = c;
      end
    end
    chk("b2b_done_count", dones, 2);
    chk("b2b_first_done", d_first, 41);
    chk("b2b_second_done", d_second, 83);

    // Asynchronous reset in the middle of cycle 20.
    dones = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", {dut_in, busy, done, match, table_out, mismatch_mask}, 32'h0);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("rst_mid_no_done", dones, 0);
    rst = 1'b0;
    do_sweep(8'h92, 1'b0, -1, dones, done_cyc, seq_err, clr_err);
    chk("rst_restart_done_cycle", done_cyc, 41);
    chk("rst_restart_table", table_out, 8'h92);
    chk("rst_restart_match", match, 1'b1);

`ifdef SWEEP_ABORT_EN
    do_sweep(8'h00, 1'b0, 15, dones, done_cyc, seq_err, clr_err);
    chk("abort_no_done", dones, 0);
    chk("abort_dut_in_busy_seq", seq_err, 0);
    chk("abort_table_restored", table_out, 8'h92);
    chk("abort_match_restored", match, 1'b1);
    chk("abort_mask_restored", mismatch_mask, 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
